// File: rtl/branch_resolve_unit_if.sv
// Branch request / redirect bundle between the EX-stage pipeline and branch_resolve_unit.
// The master side issues requests and flags; the slave side (the unit) returns redirect and status.
interface branch_resolve_unit_if;
  logic        flag_we;
  logic        z_in;
  logic        n_in;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [31:0] br_target;
  logic        br_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        z_flag;
  logic        n_flag;
  logic        bad_type;
  logic [15:0] taken_cnt;

  modport master (
    output flag_we, z_in, n_in, br_valid, br_type, br_target,
    input  br_ready, redirect, redirect_pc, flush, z_flag, n_flag, bad_type, taken_cnt
  );

  modport slave (
    input  flag_we, z_in, n_in, br_valid, br_type, br_target,
    output br_ready, redirect, redirect_pc, flush, z_flag, n_flag, bad_type, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolver: 1-cycle registered redirect, then flush for FLUSH_CYCLES with br_ready low (requests ignored).
// Optional flag forwarding of same-cycle z_in/n_in into the branch decision: BRU_FLAG_FORWARD_EN.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] BR_JMP = 2'b00;
  localparam logic [1:0] BR_BRZ = 2'b01;
  localparam logic [1:0] BR_BRN = 2'b10;
  localparam logic [1:0] BR_RSV = 2'b11;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        z_flag_q, z_flag_d;
  logic        n_flag_q, n_flag_d;
  logic        bad_type_q, bad_type_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic accept;
  logic z_use;
  logic n_use;
  logic taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0000_0000;
      z_flag_q      <= 1'b0;
      n_flag_q      <= 1'b0;
      bad_type_q    <= 1'b0;
      taken_cnt_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      z_flag_q      <= z_flag_d;
      n_flag_q      <= n_flag_d;
      bad_type_q    <= bad_type_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  always_comb begin
    accept = bus.br_valid && (state_q == S_IDLE);

`ifdef BRU_FLAG_FORWARD_EN
    z_use = bus.flag_we ? bus.z_in : z_flag_q;
    n_use = bus.flag_we ? bus.n_in : n_flag_q;
`else
    z_use = z_flag_q;
    n_use = n_flag_q;
`endif

    case (bus.br_type)
      BR_JMP:  taken = 1'b1;
      BR_BRZ:  taken = z_use;
      BR_BRN:  taken = n_use;
      default: taken = 1'b0;
    endcase

    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    z_flag_d      = z_flag_q;
    n_flag_d      = n_flag_q;
    bad_type_d    = 1'b0;
    taken_cnt_d   = taken_cnt_q;

    case (state_q)
      S_IDLE: begin
        // The flag producer is squashed during FLUSH, so flags only load while idle.
        if (bus.flag_we) begin
          z_flag_d = bus.z_in;
          n_flag_d = bus.n_in;
        end
        if (accept && taken) begin
          state_d       = S_FLUSH;
          cnt_d         = CNT_LOAD;
          redirect_d    = 1'b1;
          redirect_pc_d = bus.br_target;
          taken_cnt_d   = taken_cnt_q + 16'd1;
        end
        bad_type_d = accept && (bus.br_type == BR_RSV) && !bad_type_q;
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.br_ready    = (state_q == S_IDLE);
    bus.flush       = (state_q == S_FLUSH);
    bus.redirect    = redirect_q;
    bus.redirect_pc = redirect_pc_q;
    bus.z_flag      = z_flag_q;
    bus.n_flag      = n_flag_q;
    bus.bad_type    = bad_type_q;
    bus.taken_cnt   = taken_cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus hand sequences for reset-in-flush and counter wrap.
module tb_branch_resolve_unit;

  localparam logic [1:0] JMP = 2'b00;
  localparam logic [1:0] BRZ = 2'b01;
  localparam logic [1:0] BRN = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

`ifdef BRU_FLAG_FORWARD_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif

  typedef struct {
    logic        fwe;
    logic        zi;
    logic        ni;
    logic        vld;
    logic [1:0]  typ;
    logic [31:0] tgt;
    logic        e_red;
    logic [31:0] e_pc;
    logic        e_fl;
    logic        e_rdy;
    logic        e_bad;
    logic        e_z;
    logic        e_n;
    logic [15:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  branch_resolve_unit_if bus ();

  branch_resolve_unit #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic fwe, logic zi, logic ni, logic vld, logic [1:0] typ,
                              logic [31:0] tgt, logic e_red, logic [31:0] e_pc, logic e_fl,
                              logic e_rdy, logic e_bad, logic e_z, logic e_n, logic [15:0] e_cnt);
    vec_t v;
    v.fwe = fwe; v.zi = zi; v.ni = ni; v.vld = vld; v.typ = typ; v.tgt = tgt;
    v.e_red = e_red; v.e_pc = e_pc; v.e_fl = e_fl; v.e_rdy = e_rdy;
    v.e_bad = e_bad; v.e_z = e_z; v.e_n = e_n; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fwe, input logic zi, input logic ni, input logic vld,
                       input logic [1:0] typ, input logic [31:0] tgt);
    bus.flag_we   = fwe;
    bus.z_in      = zi;
    bus.n_in      = ni;
    bus.br_valid  = vld;
    bus.br_type   = typ;
    bus.br_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] pc12;
    n_chk  = 0;
    n_fail = 0;
    pc12   = (F != 0) ? 32'h100 : 32'h80;

    // fwe zi ni vld typ tgt | red pc fl rdy bad z n cnt
    tbl.push_back(mk(0,0,0,1,JMP,32'h40,  1,32'h40,1,0,0,0,0,16'd1));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h40,1,0,0,0,0,16'd1));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h40,0,1,0,0,0,16'd1));
    tbl.push_back(mk(1,1,0,0,JMP,32'h0,   0,32'h40,0,1,0,1,0,16'd1));
    tbl.push_back(mk(0,0,0,1,BRZ,32'h80,  1,32'h80,1,0,0,1,0,16'd2));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h80,1,0,0,1,0,16'd2));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h80,0,1,0,1,0,16'd2));
    tbl.push_back(mk(1,0,0,0,JMP,32'h0,   0,32'h80,0,1,0,0,0,16'd2));
    tbl.push_back(mk(0,0,0,1,BRZ,32'h84,  0,32'h80,0,1,0,0,0,16'd2));
    tbl.push_back(mk(0,0,0,1,BRZ,32'h88,  0,32'h80,0,1,0,0,0,16'd2));
    tbl.push_back(mk(0,0,0,1,RSV,32'h90,  0,32'h80,0,1,1,0,0,16'd2));
    tbl.push_back(mk(0,0,0,1,RSV,32'h94,  0,32'h80,0,1,0,0,0,16'd2));
    tbl.push_back(mk(1,0,1,1,BRN,32'h100, 1'(F),pc12,1'(F),1'(1-F),0,0,1,16'(2+F)));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,pc12,1'(F),1'(1-F),0,0,1,16'(2+F)));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,pc12,0,1,0,0,1,16'(2+F)));
    tbl.push_back(mk(0,0,0,1,JMP,32'h200, 1,32'h200,1,0,0,0,1,16'(3+F)));
    tbl.push_back(mk(1,1,0,1,JMP,32'h300, 0,32'h200,1,0,0,0,1,16'(3+F)));
    tbl.push_back(mk(1,1,0,1,JMP,32'h300, 0,32'h200,0,1,0,0,1,16'(3+F)));
    tbl.push_back(mk(0,0,0,1,JMP,32'h300, 1,32'h300,1,0,0,0,1,16'(4+F)));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h300,1,0,0,0,1,16'(4+F)));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h300,0,1,0,0,1,16'(4+F)));
    tbl.push_back(mk(0,0,0,1,BRN,32'h400, 1,32'h400,1,0,0,0,1,16'(5+F)));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h400,1,0,0,0,1,16'(5+F)));
    tbl.push_back(mk(0,0,0,0,JMP,32'h0,   0,32'h400,0,1,0,0,1,16'(5+F)));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, JMP, 32'h0);
    #23;
    chk("rst_ready",    {31'd0, bus.br_ready}, 32'd1);
    chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst_pc",       bus.redirect_pc,       32'h0);
    chk("rst_flush",    {31'd0, bus.flush},    32'd0);
    chk("rst_flags",    {30'd0, bus.z_flag, bus.n_flag}, 32'd0);
    chk("rst_bad",      {31'd0, bus.bad_type}, 32'd0);
    chk("rst_cnt",      {16'd0, bus.taken_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].fwe, tbl[i].zi, tbl[i].ni, tbl[i].vld, tbl[i].typ, tbl[i].tgt);
      step();
      chk($sformatf("v%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, tbl[i].e_red});
      chk($sformatf("v%0d_pc", i),       bus.redirect_pc,       tbl[i].e_pc);
      chk($sformatf("v%0d_flush", i),    {31'd0, bus.flush},    {31'd0, tbl[i].e_fl});
      chk($sformatf("v%0d_ready", i),    {31'd0, bus.br_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_bad", i),      {31'd0, bus.bad_type}, {31'd0, tbl[i].e_bad});
      chk($sformatf("v%0d_z", i),        {31'd0, bus.z_flag},   {31'd0, tbl[i].e_z});
      chk($sformatf("v%0d_n", i),        {31'd0, bus.n_flag},   {31'd0, tbl[i].e_n});
      chk($sformatf("v%0d_cnt", i),      {16'd0, bus.taken_cnt}, {16'd0, tbl[i].e_cnt});
    end

    // Reset landing in the first flush cycle must clear everything without a clock.
    @(negedge clk);
    drive(0, 0, 0, 1, JMP, 32'h500);
    step();
    drive(0, 0, 0, 0, JMP, 32'h0);
    chk("mid_flush_on",  {31'd0, bus.flush}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flush", {31'd0, bus.flush},    32'd0);
    chk("mid_rst_ready", {31'd0, bus.br_ready}, 32'd1);
    chk("mid_rst_red",   {31'd0, bus.redirect}, 32'd0);
    chk("mid_rst_pc",    bus.redirect_pc,       32'h0);
    chk("mid_rst_cnt",   {16'd0, bus.taken_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_flush", {31'd0, bus.flush},    32'd0);
    chk("post_rst_red",   {31'd0, bus.redirect}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.br_ready}, 32'd1);
    step();
    chk("post_rst_flush2", {31'd0, bus.flush}, 32'd0);

    // Counter wrap: preload the count, then two real taken JMPs.
    @(negedge clk);
    force dut.taken_cnt_q = 16'hFFFE;
    #1;
    release dut.taken_cnt_q;
    @(negedge clk);
    drive(0, 0, 0, 1, JMP, 32'h600);
    step();
    chk("wrap_ffff", {16'd0, bus.taken_cnt}, 32'h0000_FFFF);
    @(negedge clk);
    drive(0, 0, 0, 0, JMP, 32'h0);
    step();
    step();
    @(negedge clk);
    drive(0, 0, 0, 1, JMP, 32'h700);
    step();
    chk("wrap_zero",  {16'd0, bus.taken_cnt}, 32'h0);
    chk("wrap_red",   {31'd0, bus.redirect},  32'd1);
    chk("wrap_pc",    bus.redirect_pc,        32'h700);
    @(negedge clk);
    drive(0, 0, 0, 0, JMP, 32'h0);
    step();
    chk("wrap_red_off", {31'd0, bus.redirect}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is held after a taken branch (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port: flag_we  input  1  capture z_in/n_in into the flag register this cycle.
REQ-005 Port: z_in  input  1  ALU zero flag from EX stage.
REQ-006 Port: n_in  input  1  ALU negative flag from EX stage.
REQ-007 Port: br_valid  input  1  branch request present this cycle.
REQ-008 Port: br_type  input  2  00 = JMP (unconditional), 01 = BRZ, 10 = BRN, 11 = reserved.
REQ-009 Port: br_target  input  32  redirect address for the request.
REQ-010 Port: br_ready  output  1  unit accepts requests; high only in IDLE.
REQ-011 Port: redirect  output  1  registered one-cycle pulse, PC must load redirect_pc.
REQ-012 Port: redirect_pc  output  32  registered target; held until the next taken branch.
REQ-013 Port: flush  output  1  squash younger pipeline stages.
REQ-014 Port: z_flag / n_flag  output  1 each  current flag register contents.
REQ-015 Port: bad_type  output  1  registered one-cycle pulse on an accepted br_type = 11.
REQ-016 Port: taken_cnt  output  16  count of taken branches since reset.

Function
REQ-017 FSM states SHALL be IDLE and FLUSH only.
REQ-018 Accept = br_valid && br_ready; br_valid while br_ready is low SHALL be ignored, with no output or counter effect.
REQ-019 Taken condition: JMP always; BRZ iff z used == 1; BRN iff n used == 1; type 11 never taken.
REQ-020 Accepted taken branch at edge k: at k+1, redirect = 1, redirect_pc = br_target, flush = 1, state = FLUSH, and taken_cnt increments.
REQ-021 flush SHALL stay high for exactly FLUSH_CYCLES consecutive cycles starting at k+1; the FSM then returns to IDLE, and br_ready rises in the same cycle flush falls.
REQ-022 A down-counter of width 4 SHALL time FLUSH; it is loaded with FLUSH_CYCLES-1 on entry and transitions to IDLE when it reaches 0.
REQ-023 Accepted not-taken branch: no redirect, no flush, state stays IDLE, and back-to-back requests are accepted every cycle.
REQ-024 Accepted br_type = 11: bad_type pulses at k+1; otherwise identical to not-taken.
REQ-025 flag_we in IDLE SHALL update z_flag/n_flag at the next edge; flag_we in FLUSH SHALL be ignored because the producer is squashed.
REQ-026 taken_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-027 redirect and bad_type SHALL never be high for two consecutive cycles.

Reset
REQ-028 On rst_n low, immediately and without a clock, the unit SHALL set: state = IDLE; br_ready = 1; redirect = 0; redirect_pc = 0x00000000; flush = 0; z_flag = 0; n_flag = 0; bad_type = 0; taken_cnt = 0; counter = 0.
REQ-029 Reset asserted mid-FLUSH SHALL abort the flush; after release the unit is in IDLE with no residual pulse.
REQ-030 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high; no request is accepted before that edge.

Configuration
REQ-031 Macro BRU_FLAG_FORWARD_EN: when defined, an accepted branch in a cycle with flag_we = 1 SHALL evaluate z_in/n_in (forwarded).
REQ-032 Without BRU_FLAG_FORWARD_EN, branches SHALL always evaluate the registered z_flag/n_flag, including in a cycle with flag_we = 1.
REQ-033 The flag register update SHALL be identical in both builds.

Verification
REQ-034 Reset, then JMP with br_target = 0x00000040 -> next cycle redirect = 1, redirect_pc = 0x40; flush high 2 cycles; taken_cnt = 1; br_ready low 2 cycles.
REQ-035 flag_we with z_in = 1; next cycle BRZ with target 0x80 -> taken, redirect_pc = 0x80. Then flag_we with z_in = 0; next cycle BRZ -> no redirect, no flush.
REQ-036 Same cycle: flag_we with n_in = 1, n_flag = 0, BRN with target 0x100 -> taken with BRU_FLAG_FORWARD_EN defined; not taken without it.
REQ-037 JMP followed by br_valid held high for 3 cycles and flag_we = 1 with z_in = 1 during FLUSH -> only one redirect, z_flag unchanged, second request accepted on the first cycle br_ready = 1.
REQ-038 br_type = 11 -> bad_type one-cycle pulse, no redirect. Separately, rst_n low during flush cycle 1 -> flush = 0 immediately and state IDLE after release.
REQ-039 Preload 65535 taken JMPs (FLUSH_CYCLES = 1), then one more JMP -> taken_cnt = 0x0000.
